// File: rtl/wishbone_timer_pkg.sv
// Shared definitions for the wishbone machine timer: register offsets
// (word index taken from adr[4:2]), the bus FSM state type and a byte-lane
// merge helper used for sel-qualified writes.
package wishbone_timer_pkg;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_PRESCALE    = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } timer_bus_state_t;

  // Replace the bytes of old_v whose sel bit is set with the bytes of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wishbone_timer_if.sv
// Classic single-beat wishbone bus bundle.
//   master drives: cyc, stb, we, adr[31:0], sel[3:0], wdata[31:0]
//   slave drives : rdata[31:0], ack
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, wdata, input rdata, ack);
  modport slave  (input cyc, stb, we, adr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/wishbone_timer_prescaler.sv
// 16-bit prescale counter for the machine timer.
//   clk, reset : clock, async active-high reset
//   enable     : counter runs while high, held at 0 while low
//   clr        : restart the count (PRESCALE register write)
//   prescale   : terminal count; tick fires once every prescale+1 clocks
//   tick       : single-cycle increment strobe for mtime
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clr,
  input  logic [15:0] prescale,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d;

  // A PRESCALE write restarts the period, so no tick is issued in that cycle.
  assign tick = enable && !clr && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!enable || clr || tick) cnt_d = 16'd0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/wishbone_timer.sv
// Wishbone-attached RISC-V style machine timer (mtime / mtimecmp).
//   clk, reset   : clock, async active-high reset
//   wishbone_bus : slave port, word registers decoded from adr[4:2]
//   o_timer_irq  : registered irq_en && (mtime >= mtimecmp)
module wishbone_timer
  import wishbone_timer_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RESET = 16'd0,
  parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       clk,
  input  logic       reset,
  wishbone_if.slave  wishbone_bus,
  output logic       o_timer_irq
);
  timer_bus_state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] mtime_q, mtime_d;
  logic [31:0] shadow_q, shadow_d;
  logic [63:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;     // bit0 enable, bit1 irq_en
  logic [15:0] prescale_q, prescale_d;
  logic        irq_q, irq_d;

  logic        access, wr, rd, tick;
  logic [2:0]  off;
  logic [31:0] rd_val;
  logic        unused_adr;

  assign off        = wishbone_bus.adr[4:2];
  assign unused_adr = ^{wishbone_bus.adr[31:5], wishbone_bus.adr[1:0]};
  // Access is committed on the edge that moves IDLE -> ACK.
  assign access = (state_q == ST_IDLE) && wishbone_bus.cyc && wishbone_bus.stb;
  assign wr     = access && wishbone_bus.we;
  assign rd     = access && !wishbone_bus.we;

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (ctrl_q[0]),
    .clr      (wr && (off == OFF_PRESCALE)),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    rd_val = 32'd0;
    case (off)
      OFF_MTIME_LO:    rd_val = mtime_q[31:0];
      OFF_MTIME_HI:    rd_val = shadow_q;
      OFF_MTIMECMP_LO: rd_val = cmp_q[31:0];
      OFF_MTIMECMP_HI: rd_val = cmp_q[63:32];
      OFF_CTRL:        rd_val = {30'd0, ctrl_q};
      OFF_PRESCALE:    rd_val = {16'd0, prescale_q};
      default:         rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = access ? ST_ACK : ST_IDLE;
    rdata_d    = rdata_q;
    shadow_d   = shadow_q;
    cmp_d      = cmp_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    irq_d      = ctrl_q[1] && (mtime_q >= cmp_q);

    if (wr) begin
      case (off)
        // Bus write wins over the increment; the untouched half keeps its
        // pre-increment value.
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
            byte_merge(mtime_q[31:0], wishbone_bus.wdata, wishbone_bus.sel)};
        OFF_MTIME_HI: mtime_d = {byte_merge(mtime_q[63:32],
            wishbone_bus.wdata, wishbone_bus.sel), mtime_q[31:0]};
        OFF_MTIMECMP_LO: cmp_d[31:0] =
            byte_merge(cmp_q[31:0], wishbone_bus.wdata, wishbone_bus.sel);
        OFF_MTIMECMP_HI: cmp_d[63:32] =
            byte_merge(cmp_q[63:32], wishbone_bus.wdata, wishbone_bus.sel);
        OFF_CTRL:
          if (wishbone_bus.sel[0]) ctrl_d = wishbone_bus.wdata[1:0];
        OFF_PRESCALE: begin
          if (wishbone_bus.sel[0]) prescale_d[7:0]  = wishbone_bus.wdata[7:0];
          if (wishbone_bus.sel[1]) prescale_d[15:8] = wishbone_bus.wdata[15:8];
        end
        default: ;
      endcase
    end

    if (rd) begin
      rdata_d = rd_val;
      // Latch the high word so a LO-then-HI read pair is coherent.
      if (off == OFF_MTIME_LO) shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdata_q    <= 32'd0;
      mtime_q    <= 64'd0;
      shadow_q   <= 32'd0;
      cmp_q      <= CMP_RESET;
      ctrl_q     <= 2'd0;
      prescale_q <= PRESCALE_RESET;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      shadow_q   <= shadow_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      irq_q      <= irq_d;
    end
  end

  assign wishbone_bus.ack   = (state_q == ST_ACK);
  assign wishbone_bus.rdata = rdata_q;
  assign o_timer_irq        = irq_q;
endmodule

// File: tb/tb_wishbone_timer.sv
// Directed bench for wishbone_timer: bus timing, counting, prescale,
// shadowed high read, compare interrupt, byte enables, reset mid-transfer.
module tb_wishbone_timer;
  import wishbone_timer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] d;

  wishbone_if bus();

  wishbone_timer dut (
    .clk          (clk),
    .reset        (reset),
    .wishbone_bus (bus),
    .o_timer_irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge; commits on the next edge, ends 1ns after
  // the edge that returns the FSM to IDLE.
  task automatic xfer(input logic we, input logic [2:0] off, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rdv);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = {27'd0, off, 2'b00}; bus.sel = sel; bus.wdata = wd;
    @(posedge clk); #1;
    chk("ack_1cyc", bus.ack, 1'b1);
    rdv = bus.rdata;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", bus.ack, 1'b0);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(1'b1, off, 4'hF, wd, dummy);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] rdv);
    xfer(1'b0, off, 4'hF, 32'd0, rdv);
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = 32'd0; bus.sel = 4'h0; bus.wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rd(OFF_MTIME_LO, d);    chk("rst_mtime_lo", d, 32'h0);
    rd(OFF_MTIMECMP_LO, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(OFF_MTIMECMP_HI, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(OFF_CTRL, d);        chk("rst_ctrl", d, 32'h0);
    rd(OFF_PRESCALE, d);    chk("rst_prescale", d, 32'h0);

    // Byte enables, reserved bits and unmapped offsets
    begin
      logic [31:0] dummy;
      xfer(1'b1, OFF_MTIMECMP_LO, 4'b0010, 32'hAABB_CCDD, dummy);
    end
    rd(OFF_MTIMECMP_LO, d); chk("sel_cmp_lo", d, 32'hFFFF_CCFF);
    rd(3'd6, d);            chk("off6_read", d, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, d);            chk("off7_read", d, 32'h0);
    wr(OFF_CTRL, 32'hFFFF_FFFC);
    rd(OFF_CTRL, d);        chk("ctrl_rsvd", d, 32'h0);
    wr(OFF_PRESCALE, 32'hABCD_1234);
    rd(OFF_PRESCALE, d);    chk("prescale_rsvd", d, 32'h0000_1234);
    wr(OFF_PRESCALE, 32'h0);

    // Free-running at PRESCALE=0: one increment per clock
    wr(OFF_CTRL, 32'h1);
    rd(OFF_MTIME_LO, d);    chk("run_n", d, 32'd1);
    repeat (5) @(posedge clk); #1;
    rd(OFF_MTIME_LO, d);    chk("run_n_plus", d, 32'd8);

    // PRESCALE=3: one increment per 4 clocks; rewrite restarts the period
    wr(OFF_CTRL, 32'h0);
    wr(OFF_MTIME_LO, 32'h0);
    wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_PRESCALE, 32'h3);
    wr(OFF_CTRL, 32'h1);
    rd(OFF_MTIME_LO, d);    chk("ps3_c2", d, 32'd0);
    repeat (1) @(posedge clk); #1;
    rd(OFF_MTIME_LO, d);    chk("ps3_c5", d, 32'd1);
    repeat (2) @(posedge clk); #1;
    rd(OFF_MTIME_LO, d);    chk("ps3_c9", d, 32'd2);
    wr(OFF_PRESCALE, 32'h3);
    rd(OFF_MTIME_LO, d);    chk("ps_rewr_c13", d, 32'd2);
    rd(OFF_MTIME_LO, d);    chk("ps_rewr_c15", d, 32'd2);
    rd(OFF_MTIME_LO, d);    chk("ps_rewr_c17", d, 32'd3);

    // Coherent LO/HI reads across the 32-bit carry
    wr(OFF_CTRL, 32'h0);
    wr(OFF_PRESCALE, 32'h0);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
    wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_CTRL, 32'h1);
    rd(OFF_MTIME_LO, d);    chk("wrap_lo", d, 32'h0);
    rd(OFF_MTIME_HI, d);    chk("wrap_hi", d, 32'h1);
    wr(OFF_CTRL, 32'h0);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFE);
    wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_CTRL, 32'h1);
    rd(OFF_MTIME_LO, d);    chk("shadow_lo", d, 32'hFFFF_FFFF);
    rd(OFF_MTIME_HI, d);    chk("shadow_hi", d, 32'h0);

    // Compare interrupt
    wr(OFF_CTRL, 32'h0);
    wr(OFF_MTIME_LO, 32'h0);
    wr(OFF_MTIME_HI, 32'h0);
    wr(OFF_MTIMECMP_LO, 32'h10);
    wr(OFF_MTIMECMP_HI, 32'h0);
    wr(OFF_CTRL, 32'h3);
    repeat (15) @(posedge clk); #1;
    chk("irq_before", irq, 1'b0);
    @(posedge clk); #1;
    chk("irq_rise", irq, 1'b1);
    wr(OFF_MTIMECMP_HI, 32'h1);
    chk("irq_clear", irq, 1'b0);
    wr(OFF_MTIMECMP_HI, 32'h0);
    chk("irq_again", irq, 1'b1);

    // Reset asserted while ack is high
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = {27'd0, OFF_MTIMECMP_LO, 2'b00}; bus.sel = 4'hF; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("pre_rst_ack", bus.ack, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_async_ack", bus.ack, 1'b0);
    chk("rst_async_irq", irq, 1'b0);
    bus.we = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ack", bus.ack, 1'b1);
    chk("post_rst_cmp_lo", bus.rdata, 32'hFFFF_FFFF);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", bus.ack, 1'b0);
    rd(OFF_MTIMECMP_HI, d); chk("post_rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(OFF_CTRL, d);        chk("post_rst_ctrl", d, 32'h0);
    rd(OFF_MTIME_LO, d);    chk("post_rst_mtime", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
